// File: rtl/mix_dispense_if.sv
`default_nettype none
// ============================================================================
// Module      : mix_dispense_if
// Description : Control/status bundle between a dispense requester and the
//               mix_dispense_ctrl inlet sequencer.
//               master : drives start/abort/volumes, observes valves/status
//               slave  : the sequencer side
//   start, abort            request / cancel a dispense run
//   vol_soln1..3 [CNT_W]    pump steps per solution
//   valve_soln1..3, flush   valve drive outputs
//   pump_step               one pump step per asserted cycle
//   active_ch [2]           channel being served (0 = none)
//   busy, done              run in progress / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface mix_dispense_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] vol_soln1;
    logic [CNT_W-1:0] vol_soln2;
    logic [CNT_W-1:0] vol_soln3;
    logic             valve_soln1;
    logic             valve_soln2;
    logic             valve_soln3;
    logic             valve_flush;
    logic             pump_step;
    logic [1:0]       active_ch;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, vol_soln1, vol_soln2, vol_soln3,
        input  valve_soln1, valve_soln2, valve_soln3, valve_flush,
        input  pump_step, active_ch, busy, done
    );

    modport slave (
        input  start, abort, vol_soln1, vol_soln2, vol_soln3,
        output valve_soln1, valve_soln2, valve_soln3, valve_flush,
        output pump_step, active_ch, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mix_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mix_dispense_ctrl
// Description : Inlet sequencer for a three-solution passive mixer. Captures
//               per-solution pump-step volumes on start, then serves each
//               nonzero channel in index order: valve settle, pump, valve
//               close. Optionally flushes the outlet, then pulses done.
//               Compile-time option: MIX_DISPENSE_FLUSH_EN enables the flush
//               phase (otherwise valve_flush is tied low).
// Ports       : clk  - system clock
//               rst  - synchronous active-high reset
//               bus  - mix_dispense_if.slave (start/abort/volumes in,
//                      valves/pump/active_ch/busy/done out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module mix_dispense_ctrl #(
    parameter int CNT_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int FLUSH_CYCLES  = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mix_dispense_if.slave     bus
);

    // Phase timer counts down from N-1 to 0; sized for the longer phase.
    localparam int TMR_MAX = (SETTLE_CYCLES > FLUSH_CYCLES) ? SETTLE_CYCLES : FLUSH_CYCLES;
    localparam int TMR_W   = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] C_SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
`ifdef MIX_DISPENSE_FLUSH_EN
    localparam logic [TMR_W-1:0] C_FLUSH_LOAD  = TMR_W'(FLUSH_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_PUMP   = 3'd2,
        S_CLOSE  = 3'd3,
        S_DONE   = 3'd4
`ifdef MIX_DISPENSE_FLUSH_EN
        ,
        S_FLUSH  = 3'd5
`endif
    } state_t;

    state_t           r_state, w_state_n;
    logic [1:0]       r_ch, w_ch_n;
    logic [TMR_W-1:0] r_tmr, w_tmr_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [CNT_W-1:0] r_vol1, r_vol2, r_vol3;
    logic [CNT_W-1:0] w_sel_vol;
    logic [1:0]       w_first_ch, w_after_ch;
    logic             w_cap;
    logic             w_valve1, w_valve2, w_valve3, w_pump, w_busy, w_done;
    logic [1:0]       w_active;

    // Lowest-index nonzero channel strictly above cur (0 if none).
    function automatic logic [1:0] f_next_ch(input logic [1:0] cur,
                                             input logic nz1, input logic nz2,
                                             input logic nz3);
        logic [1:0] res;
        res = 2'd0;
        if (cur < 2'd3 && nz3) res = 2'd3;
        if (cur < 2'd2 && nz2) res = 2'd2;
        if (cur < 2'd1 && nz1) res = 2'd1;
        return res;
    endfunction

    assign w_first_ch = f_next_ch(2'd0, |bus.vol_soln1, |bus.vol_soln2, |bus.vol_soln3);
    assign w_after_ch = f_next_ch(r_ch, |r_vol1, |r_vol2, |r_vol3);
    assign w_sel_vol  = (r_ch == 2'd1) ? r_vol1 : (r_ch == 2'd2) ? r_vol2 : r_vol3;

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        w_ch_n    = r_ch;
        w_tmr_n   = r_tmr;
        w_cnt_n   = r_cnt;
        w_cap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_cap  = 1'b1;
                    w_ch_n = w_first_ch;
                    if (w_first_ch != 2'd0) begin
                        w_state_n = S_SETTLE;
                        w_tmr_n   = C_SETTLE_LOAD;
                    end else begin
                        w_state_n = S_DONE;
                    end
                end
            end
            S_SETTLE: begin
                if (r_tmr == '0) begin
                    w_state_n = S_PUMP;
                    // Selected channel is nonzero, so vol-1 cannot underflow.
                    w_cnt_n   = w_sel_vol - CNT_W'(1);
                end else begin
                    w_tmr_n = r_tmr - TMR_W'(1);
                end
            end
            S_PUMP: begin
                if (r_cnt == '0) begin
                    w_state_n = S_CLOSE;
                    w_tmr_n   = C_SETTLE_LOAD;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            S_CLOSE: begin
                if (r_tmr == '0) begin
                    if (w_after_ch != 2'd0) begin
                        w_state_n = S_SETTLE;
                        w_ch_n    = w_after_ch;
                        w_tmr_n   = C_SETTLE_LOAD;
                    end else begin
                        w_ch_n = 2'd0;
`ifdef MIX_DISPENSE_FLUSH_EN
                        w_state_n = S_FLUSH;
                        w_tmr_n   = C_FLUSH_LOAD;
`else
                        w_state_n = S_DONE;
`endif
                    end
                end else begin
                    w_tmr_n = r_tmr - TMR_W'(1);
                end
            end
`ifdef MIX_DISPENSE_FLUSH_EN
            S_FLUSH: begin
                if (r_tmr == '0) begin
                    w_state_n = S_DONE;
                end else begin
                    w_tmr_n = r_tmr - TMR_W'(1);
                end
            end
`endif
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        // Abort cancels any run without a done pulse.
        if (bus.abort && r_state != S_IDLE) begin
            w_state_n = S_IDLE;
            w_ch_n    = 2'd0;
        end
    end

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and have no input-to-output path.
    always_comb begin
        w_valve1 = 1'b0;
        w_valve2 = 1'b0;
        w_valve3 = 1'b0;
        w_active = 2'd0;
        w_busy   = 1'b0;
        w_pump   = (w_state_n == S_PUMP);
        w_done   = (w_state_n == S_DONE);
        if (w_state_n == S_SETTLE || w_state_n == S_PUMP) begin
            w_valve1 = (w_ch_n == 2'd1);
            w_valve2 = (w_ch_n == 2'd2);
            w_valve3 = (w_ch_n == 2'd3);
        end
        if (w_state_n == S_SETTLE || w_state_n == S_PUMP || w_state_n == S_CLOSE) begin
            w_active = w_ch_n;
            w_busy   = 1'b1;
        end
`ifdef MIX_DISPENSE_FLUSH_EN
        if (w_state_n == S_FLUSH) begin
            w_pump = 1'b1;
            w_busy = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ch            <= 2'd0;
            r_tmr           <= '0;
            r_cnt           <= '0;
            r_vol1          <= '0;
            r_vol2          <= '0;
            r_vol3          <= '0;
            bus.valve_soln1 <= 1'b0;
            bus.valve_soln2 <= 1'b0;
            bus.valve_soln3 <= 1'b0;
            bus.pump_step   <= 1'b0;
            bus.active_ch   <= 2'd0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            r_state         <= w_state_n;
            r_ch            <= w_ch_n;
            r_tmr           <= w_tmr_n;
            r_cnt           <= w_cnt_n;
            if (w_cap) begin
                r_vol1 <= bus.vol_soln1;
                r_vol2 <= bus.vol_soln2;
                r_vol3 <= bus.vol_soln3;
            end
            bus.valve_soln1 <= w_valve1;
            bus.valve_soln2 <= w_valve2;
            bus.valve_soln3 <= w_valve3;
            bus.pump_step   <= w_pump;
            bus.active_ch   <= w_active;
            bus.busy        <= w_busy;
            bus.done        <= w_done;
        end
    end

`ifdef MIX_DISPENSE_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.valve_flush <= 1'b0;
        end else begin
            bus.valve_flush <= (w_state_n == S_FLUSH);
        end
    end
`else
    assign bus.valve_flush = 1'b0;
`endif

endmodule
`default_nettype wire
